shift_unit: RTL and testbench
=============================

SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand and result width.
REQ-002 The block SHALL have parameter SHAMT_W, default 5, giving the shift-amount width; DATA_W SHALL equal 2**SHAMT_W.
REQ-003 The block SHALL have parameter CONST_SHAMT, default 16, giving the fixed amount selected by src_sel=01.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  sole clock, all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 start  in  1  request to begin a shift; sampled only in IDLE or DONE.
REQ-007 op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-008 src_sel  in  2  amount source: 00 b_in, 01 CONST_SHAMT, 10 instr_shamt, 11 zero.
REQ-009 data_in  in  DATA_W  operand.
REQ-010 b_in  in  SHAMT_W  register-sourced amount.
REQ-011 instr_shamt  in  SHAMT_W  instruction shamt field.
REQ-012 data_out  out  DATA_W  working/result register.
REQ-013 shamt_out  out  SHAMT_W  amount latched at start.
REQ-014 busy  out  1  high while shifting.
REQ-015 done  out  1  one-cycle pulse when data_out holds the final result.

Function
REQ-016 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-017 On a rising edge with start=1 in IDLE or DONE, the block SHALL load data_out<=data_in, latch op, and latch the selected amount into the down-counter and shamt_out.
REQ-018 After the load, the next state SHALL be DONE if the amount is 0, otherwise SHIFT.
REQ-019 In SHIFT, each edge SHALL shift data_out by exactly one position per op and decrement the counter; the FSM SHALL go to DONE when the counter goes from 1 to 0.
REQ-020 Shift fill rules: SLL fills 0 at the LSB; SRL fills 0 at the MSB; SRA replicates the MSB; ROR moves the LSB into the MSB.
REQ-021 Latency: with start sampled in cycle 0 and amount k, done SHALL be high exactly in cycle k+1 (amount 0 gives cycle 1); busy SHALL be high in cycles 1..k.
REQ-022 DONE SHALL last one cycle, then return to IDLE unless start=1, which SHALL begin a new operation (back-to-back, no bubble).
REQ-023 start in SHIFT SHALL be ignored, with no effect on data_out, counter, op or shamt_out.
REQ-024 data_out SHALL hold the result unchanged in IDLE until the next accepted start; changes on data_in, b_in, instr_shamt, op or src_sel after acceptance SHALL have no effect.
REQ-025 Amount 2**SHAMT_W-1 (31) SHALL be supported; amounts are never reduced modulo anything other than the SHAMT_W width.

Reset
REQ-026 With reset=1 at an edge, the FSM SHALL go to IDLE and data_out, shamt_out, counter, busy and done SHALL all be 0, regardless of state, including mid-SHIFT.
REQ-027 Reset SHALL take priority over start in the same cycle.

Verification
REQ-028 SLL, src_sel=01, data_in=0x0000ABCD -> done in cycle 17, data_out=0xABCD0000, shamt_out=16.
REQ-029 SRA, src_sel=00, b_in=4, data_in=0x80000000 -> done in cycle 5, data_out=0xF8000000; SRL with the same inputs -> 0x08000000.
REQ-030 SRL, src_sel=10, instr_shamt=31, data_in=0x80000000 -> done in cycle 32, data_out=0x00000001, busy high in cycles 1..31.
REQ-031 src_sel=11, any op, data_in=0x12345678 -> done in cycle 1, busy never high, data_out=0x12345678.
REQ-032 ROR with amount 8 on 0x12345678 -> 0x78123456; a second start during SHIFT is ignored; a start held in the DONE cycle launches the next operation, whose done follows amount+1 cycles later.
REQ-033 reset asserted in cycle 3 of a 16-cycle SLL -> next cycle IDLE, all outputs 0, no done pulse; the next start behaves per REQ-021.

Source files
------------

// File: rtl/shift_unit.sv
// Iterative shifter: loads an operand on start, then shifts it one bit per clock
// for the selected amount, pulsing done when data_out holds the result.
module shift_unit #(
  parameter int DATA_W      = 32,
  parameter int SHAMT_W     = 5,
  parameter int CONST_SHAMT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [1:0]         src_sel,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [SHAMT_W-1:0] b_in,
  input  logic [SHAMT_W-1:0] instr_shamt,
  output logic [DATA_W-1:0]  data_out,
  output logic [SHAMT_W-1:0] shamt_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [SHAMT_W-1:0] LP_CONST = SHAMT_W'(CONST_SHAMT);
  localparam logic [SHAMT_W-1:0] LP_ONE   = SHAMT_W'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_data;
  logic [SHAMT_W-1:0]  r_cnt;
  logic [SHAMT_W-1:0]  r_shamt;
  logic [1:0]          r_op;
  logic [SHAMT_W-1:0]  w_amt;
  logic                w_accept;

  function automatic logic [DATA_W-1:0] shift_one(input logic [DATA_W-1:0] d,
                                                  input logic [1:0] o);
    case (o)
      OP_SLL:  shift_one = {d[DATA_W-2:0], 1'b0};
      OP_SRL:  shift_one = {1'b0, d[DATA_W-1:1]};
      OP_SRA:  shift_one = {d[DATA_W-1], d[DATA_W-1:1]};
      default: shift_one = {d[0], d[DATA_W-1:1]};
    endcase
  endfunction

  always_comb begin
    w_amt = '0;
    case (src_sel)
      2'b00:   w_amt = b_in;
      2'b01:   w_amt = LP_CONST;
      2'b10:   w_amt = instr_shamt;
      default: w_amt = '0;
    endcase
  end

  // start is only honoured outside SHIFT, so a mid-shift request cannot disturb the operation
  assign w_accept = start && (r_state != S_SHIFT);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SHIFT: begin
        if (r_cnt == LP_ONE) w_state_nxt = S_DONE;
      end
      default: begin
        if (start) w_state_nxt = (w_amt == '0) ? S_DONE : S_SHIFT;
        else       w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_cnt   <= '0;
      r_shamt <= '0;
      r_op    <= '0;
    end else if (w_accept) begin
      r_data  <= data_in;
      r_cnt   <= w_amt;
      r_shamt <= w_amt;
      r_op    <= op;
    end else if (r_state == S_SHIFT) begin
      r_data  <= shift_one(r_data, r_op);
      r_cnt   <= r_cnt - LP_ONE;
    end
  end

  assign data_out  = r_data;
  assign shamt_out = r_shamt;
  assign busy      = (r_state == S_SHIFT);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed vector table, multi-cycle corner
// sequences and randomized operations compared against an arithmetic model.
module tb_shift_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [1:0]  src_sel = '0;
  logic [31:0] data_in = '0;
  logic [4:0]  b_in = '0;
  logic [4:0]  instr_shamt = '0;
  logic [31:0] data_out;
  logic [4:0]  shamt_out;
  logic        busy;
  logic        done;

  int nchecks = 0;
  int nerr = 0;
  logic [31:0] last_exp = '0;

  shift_unit #(.DATA_W(32), .SHAMT_W(5), .CONST_SHAMT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_sel(src_sel),
    .data_in(data_in), .b_in(b_in), .instr_shamt(instr_shamt),
    .data_out(data_out), .shamt_out(shamt_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  sel;
    logic [31:0] d;
    logic [4:0]  b;
    logic [4:0]  is;
    logic [31:0] exp;
    int          k;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int model_amt(input logic [1:0] sel, input logic [4:0] b, input logic [4:0] is);
    case (sel)
      2'b00:   return int'(b);
      2'b01:   return 16;
      2'b10:   return int'(is);
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] d, input int k);
    logic [63:0] dd;
    case (o)
      2'b00: return d << k;
      2'b01: return d >> k;
      2'b10: return 32'($signed(d) >>> k);
      default: begin
        dd = {d, d};
        return dd[31:0] >> k | (k == 0 ? 32'h0 : d << (32 - k));
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    op = 2'($urandom);
    src_sel = 2'($urandom);
    data_in = $urandom;
    b_in = 5'($urandom);
    instr_shamt = 5'($urandom);
  endtask

  // Launch one operation from IDLE or DONE and follow it to its done cycle.
  task automatic run_op(input string name, input logic [1:0] o, input logic [1:0] sel,
                        input logic [31:0] d, input logic [4:0] b, input logic [4:0] is,
                        input logic [31:0] exp_d, input int k, input int poke);
    int cyc;
    op = o; src_sel = sel; data_in = d; b_in = b; instr_shamt = is;
    start = 1'b1;
    tick();
    start = 1'b0;
    scramble();
    cyc = 1;
    while (done !== 1'b1 && cyc <= 40) begin
      chk({name, " busy"}, 32'(busy), 32'd1);
      if (cyc == poke) begin
        scramble();
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    chk({name, " done_cycle"}, 32'(cyc), 32'(k + 1));
    chk({name, " done"}, 32'(done), 32'd1);
    chk({name, " busy_in_done"}, 32'(busy), 32'd0);
    chk({name, " data"}, data_out, exp_d);
    chk({name, " shamt"}, 32'(shamt_out), 32'(k));
    last_exp = exp_d;
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      scramble();
      start = 1'b0;
      tick();
      chk({name, " hold_data"}, data_out, last_exp);
      chk({name, " idle_busy"}, 32'(busy), 32'd0);
      chk({name, " idle_done"}, 32'(done), 32'd0);
    end
  endtask

  task automatic run_random(input string name, input int poke);
    logic [1:0] o, s;
    logic [31:0] d;
    logic [4:0] b, is;
    int k;
    o = 2'($urandom); s = 2'($urandom); d = $urandom;
    b = 5'($urandom); is = 5'($urandom);
    k = model_amt(s, b, is);
    run_op(name, o, s, d, b, is, model_res(o, d, k), k, poke);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{2'b00, 2'b01, 32'h0000ABCD, 5'd0,  5'd0,  32'hABCD0000, 16};
    vecs[1]  = '{2'b10, 2'b00, 32'h80000000, 5'd4,  5'd0,  32'hF8000000, 4};
    vecs[2]  = '{2'b01, 2'b00, 32'h80000000, 5'd4,  5'd0,  32'h08000000, 4};
    vecs[3]  = '{2'b01, 2'b10, 32'h80000000, 5'd0,  5'd31, 32'h00000001, 31};
    vecs[4]  = '{2'b00, 2'b11, 32'h12345678, 5'd7,  5'd9,  32'h12345678, 0};
    vecs[5]  = '{2'b11, 2'b11, 32'h12345678, 5'd3,  5'd3,  32'h12345678, 0};
    vecs[6]  = '{2'b11, 2'b00, 32'h12345678, 5'd8,  5'd0,  32'h78123456, 8};
    vecs[7]  = '{2'b00, 2'b00, 32'hFFFFFFFF, 5'd1,  5'd0,  32'hFFFFFFFE, 1};
    vecs[8]  = '{2'b11, 2'b10, 32'h80000001, 5'd0,  5'd31, 32'h00000003, 31};
    vecs[9]  = '{2'b10, 2'b00, 32'h7FFFFFFF, 5'd31, 5'd0,  32'h00000000, 31};
    vecs[10] = '{2'b10, 2'b00, 32'h80000000, 5'd31, 5'd0,  32'hFFFFFFFF, 31};
    vecs[11] = '{2'b10, 2'b01, 32'hC0FFEE00, 5'd0,  5'd0,  32'hFFFFC0FF, 16};

    // Reset state
    tick(); tick();
    chk("rst data", data_out, 32'h0);
    chk("rst shamt", 32'(shamt_out), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst done", 32'(done), 32'h0);
    reset = 1'b0;
    idle_cycles("post_rst", 2);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].sel, vecs[i].d, vecs[i].b,
             vecs[i].is, vecs[i].exp, vecs[i].k, 0);
      idle_cycles($sformatf("vec%0d", i), 2);
    end

    // Start during SHIFT is ignored; start held in DONE launches back-to-back
    run_op("ror_poke", 2'b11, 2'b00, 32'h12345678, 5'd8, 5'd0, 32'h78123456, 8, 3);
    run_op("b2b_1", 2'b01, 2'b00, 32'hF0000000, 5'd5, 5'd0, 32'h07800000, 5, 5);
    run_op("b2b_2", 2'b00, 2'b11, 32'hA5A5A5A5, 5'd9, 5'd9, 32'hA5A5A5A5, 0, 0);
    run_op("b2b_3", 2'b11, 2'b10, 32'h0000000F, 5'd0, 5'd4, 32'hF0000000, 4, 0);
    idle_cycles("b2b", 3);

    // Reset in cycle 3 of a 16-cycle SLL
    op = 2'b00; src_sel = 2'b01; data_in = 32'h0000ABCD;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst data", data_out, 32'h0);
    chk("midrst shamt", 32'(shamt_out), 32'h0);
    chk("midrst busy", 32'(busy), 32'h0);
    chk("midrst done", 32'(done), 32'h0);
    last_exp = 32'h0;
    idle_cycles("midrst", 20);
    run_op("after_rst", 2'b00, 2'b01, 32'h0000ABCD, 5'd0, 5'd0, 32'hABCD0000, 16, 0);
    idle_cycles("after_rst", 1);

    // Reset wins over start in the same cycle
    op = 2'b01; src_sel = 2'b00; b_in = 5'd6; data_in = 32'hDEADBEEF;
    start = 1'b1; reset = 1'b1;
    tick();
    start = 1'b0; reset = 1'b0;
    chk("rst_prio data", data_out, 32'h0);
    chk("rst_prio busy", 32'(busy), 32'h0);
    chk("rst_prio done", 32'(done), 32'h0);
    last_exp = 32'h0;
    idle_cycles("rst_prio", 2);

    // Randomized operations with random gaps (0 = back-to-back) and random mid-shift starts
    for (int i = 0; i < 40; i++) begin
      run_random($sformatf("rnd%0d", i), int'($urandom_range(0, 6)));
      idle_cycles($sformatf("rnd%0d", i), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
